// File: rtl/sram_rd_arbiter_if.sv
// Signal bundle around sram_rd_arbiter: requester handshake, tagged responses
// and the SRAM read port. master = requesters plus SRAM macro; slave = arbiter.
interface sram_rd_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          sram_rd_en;
  logic [ADDR_WIDTH-1:0]         sram_rd_addr;
  logic [DATA_WIDTH-1:0]         sram_rd_data;
  logic                          busy;

  modport master (
    output req_valid, req_addr, sram_rd_data,
    input  req_ready, rsp_valid, rsp_data, sram_rd_en, sram_rd_addr, busy
  );

  modport slave (
    input  req_valid, req_addr, sram_rd_data,
    output req_ready, rsp_valid, rsp_data, sram_rd_en, sram_rd_addr, busy
  );
endinterface

// File: rtl/sram_rd_arbiter.sv
// Single SRAM read-port arbiter: round-robin with bounded bursts, registered
// read port, and a tag pipeline that routes read data back to its requester.
// Optional feature: define SRAM_ARB_FETCH_PRIO_EN to give requester 0
// (microcode fetch) absolute priority without disturbing the RR order.
module sram_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 128,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rst,
  sram_rd_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic valid;
    idx_t idx;
  } tag_t;

  idx_t                  last_grant;
  cnt_t                  burst_cnt;
  logic                  burst_act;   // previous cycle was a transfer to last_grant
  idx_t                  grant_idx;
  logic                  grant_any;
  logic                  fetch_win;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [NUM_REQ-1:0]    ready;
  logic [NUM_REQ-1:0]    rsp_vec;
  logic                  tag_busy;
  tag_t                  tag_q [RD_LATENCY+1];

  // Winner selection: burst continuation first, otherwise RR from last_grant+1.
  // When the burst limit is hit, the RR search naturally reaches last_grant
  // last, so it only wins again if nobody else is valid.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_idx = last_grant;
    grant_any = 1'b0;
    fetch_win = 1'b0;
    if (burst_act && bus.req_valid[last_grant] && (int'(burst_cnt) < MAX_BURST - 1)) begin
      grant_any = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!grant_any && bus.req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
          grant_idx = idx_t'((int'(last_grant) + k) % NUM_REQ);
          grant_any = 1'b1;
        end
      end
    end
`ifdef SRAM_ARB_FETCH_PRIO_EN
    if (bus.req_valid[0]) begin
      grant_idx = '0;
      grant_any = 1'b1;
      fetch_win = 1'b1;
    end
`endif
    if (rst) grant_any = 1'b0;
  end

  // One-hot ready decode of the winner.
  always_comb begin
    ready = '0;
    if (grant_any) ready[grant_idx] = 1'b1;
  end

  assign grant_addr = bus.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];

  // RR pointer and burst tracking; fetch-priority grants leave the RR order alone.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (rst) begin
      last_grant <= idx_t'(NUM_REQ - 1);
      burst_cnt  <= '0;
      burst_act  <= 1'b0;
    end else if (!grant_any || fetch_win) begin
      burst_cnt  <= '0;
      burst_act  <= 1'b0;
    end else begin
      last_grant <= grant_idx;
      burst_act  <= 1'b1;
      if (burst_act && grant_idx == last_grant) begin
        if (int'(burst_cnt) < MAX_BURST - 1) burst_cnt <= burst_cnt + cnt_t'(1);
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  // Registered SRAM read port; the address holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sram_rd_en   <= 1'b0;
      bus.sram_rd_addr <= '0;
    end else begin
      bus.sram_rd_en <= grant_any;
      if (grant_any) bus.sram_rd_addr <= grant_addr;
    end
  end

  // Tag pipeline: stage 0 aligns with sram_rd_en, stage RD_LATENCY with read data.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the tag stages carry valid bits, so they are reset; an uncleared stage would emit a stale response.
    if (rst) begin
      for (int k = 0; k <= RD_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag_t'{valid: grant_any, idx: grant_idx};
      for (int k = 1; k <= RD_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // In-flight detection across all tag stages.
  always_comb begin
    tag_busy = 1'b0;
    for (int k = 0; k <= RD_LATENCY; k++) tag_busy = tag_busy | tag_q[k].valid;
  end

  // Response owner decode from the output stage.
  always_comb begin
    rsp_vec = '0;
    if (tag_q[RD_LATENCY].valid) rsp_vec[tag_q[RD_LATENCY].idx] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_vec;
  assign bus.rsp_data  = bus.sram_rd_data;
  assign bus.busy      = !rst && ((|bus.req_valid) || tag_busy);
endmodule
